// File: rtl/decoder_command_scheduler_if.sv
// ============================================================================
// Module      : decoder_command_scheduler_if
// Description : Command, frame-progress and engine handshake bundle between
//               the decoder top level and the post-decode command scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface decoder_command_scheduler_if #(
    parameter int BLOCK_COUNT_WIDTH = 11
);
    logic                         cmd_valid;
    logic [15:0]                  command;
    logic                         cmd_ready;
    logic                         new_frame;
    logic                         block_done;
    logic                         histogram_generated;
    logic                         CDF_generated;
    logic                         cdf_start;
    logic                         op_start;
    logic [5:0]                   op_sel;
    logic                         op_done;
    logic                         cmd_done;
    logic                         cmd_error;
    logic                         frame_complete;
    logic [BLOCK_COUNT_WIDTH-1:0] block_count;

    // Decoder / requester side.
    modport master (
        output cmd_valid, command, new_frame, block_done,
               histogram_generated, CDF_generated, op_done,
        input  cmd_ready, cdf_start, op_start, op_sel, cmd_done, cmd_error,
               frame_complete, block_count
    );

    // Scheduler side.
    modport slave (
        input  cmd_valid, command, new_frame, block_done,
               histogram_generated, CDF_generated, op_done,
        output cmd_ready, cdf_start, op_start, op_sel, cmd_done, cmd_error,
               frame_complete, block_count
    );
endinterface

`default_nettype wire

// File: rtl/decoder_command_scheduler.sv
// ============================================================================
// Module      : decoder_command_scheduler
// Description : Sequences post-decode image operations: tracks frame progress,
//               waits for prerequisites and issues one-hot engine starts.
//               Optional watchdog enabled by defining SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_command_scheduler #(
    parameter int IMAGE_WIDTH       = 320,
    parameter int IMAGE_HEIGHT      = 240,
    parameter int TABLE_EDGE_SIZE   = 8,
    parameter int TOTAL_BLOCKS      = (IMAGE_WIDTH/TABLE_EDGE_SIZE)*(IMAGE_HEIGHT/TABLE_EDGE_SIZE),
    parameter int BLOCK_COUNT_WIDTH = $clog2(TOTAL_BLOCKS+1),
    parameter int TIMEOUT_CYCLES    = 65535
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    decoder_command_scheduler_if.slave   bus
);

    localparam logic [2:0] c_IDLE        = 3'd0;
    localparam logic [2:0] c_WAIT_PREREQ = 3'd1;
    localparam logic [2:0] c_WAIT_CDF    = 3'd2;
    localparam logic [2:0] c_RUN         = 3'd3;
    localparam logic [2:0] c_DONE        = 3'd4;

    localparam logic [BLOCK_COUNT_WIDTH-1:0] c_TOTAL      = BLOCK_COUNT_WIDTH'(TOTAL_BLOCKS);
    localparam logic [BLOCK_COUNT_WIDTH-1:0] c_TOTAL_LAST = BLOCK_COUNT_WIDTH'(TOTAL_BLOCKS - 1);

    logic [2:0]                   r_state;
    logic [5:0]                   r_op_sel;
    logic                         r_op_start;
    logic                         r_cmd_error;
    logic [BLOCK_COUNT_WIDTH-1:0] r_block_count;
    logic                         r_frame_complete;

    logic [5:0]                   w_dec_sel;
    logic                         w_known;
    logic                         w_needs_hist;
    logic                         w_needs_cdf;
    logic                         w_prereq_met;
    logic                         w_timeout;

    // ------------------------------------------------------------------
    // Frame progress: saturating block counter, independent of the FSM.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_block_count    <= '0;
            r_frame_complete <= 1'b0;
        end else if (bus.new_frame) begin
            r_block_count    <= '0;
            r_frame_complete <= 1'b0;
        end else if (bus.block_done && (r_block_count != c_TOTAL)) begin
            r_block_count <= r_block_count + 1'b1;
            if (r_block_count == c_TOTAL_LAST) begin
                r_frame_complete <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Command decode to one-hot engine select.
    // ------------------------------------------------------------------
    always_comb begin
        w_known   = 1'b1;
        w_dec_sel = 6'b000000;
        case (bus.command)
            16'hA010: w_dec_sel = 6'b000001;
            16'hA020: w_dec_sel = 6'b000010;
            16'hA030: w_dec_sel = 6'b000100;
            16'hA040: w_dec_sel = 6'b001000;
            16'hA050: w_dec_sel = 6'b010000;
            16'hA060: w_dec_sel = 6'b100000;
            default:  w_known   = 1'b0;
        endcase
    end

    // Histogram statistics and equalization both depend on the histogram;
    // only equalization also needs the CDF.
    assign w_needs_hist = r_op_sel[3] | r_op_sel[4];
    assign w_needs_cdf  = r_op_sel[4];
    assign w_prereq_met = r_frame_complete && (!w_needs_hist || bus.histogram_generated);

`ifdef SCHED_TIMEOUT_EN
    localparam int c_WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [c_WDOG_W-1:0] r_wdog;
    logic                w_wdog_active;
    logic                w_enter_run;

    assign w_wdog_active = (r_state == c_WAIT_CDF) || (r_state == c_RUN);
    assign w_enter_run   = (r_state == c_WAIT_CDF) && bus.CDF_generated;
    assign w_timeout     = w_wdog_active && (r_wdog == c_WDOG_LAST);

    // Held at zero outside the guarded states so every entry starts clean;
    // the WAIT_CDF to RUN hop restarts it explicitly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wdog <= '0;
        end else if (!w_wdog_active || w_enter_run || w_timeout) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Command sequencing FSM.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_op_sel    <= '0;
            r_op_start  <= 1'b0;
            r_cmd_error <= 1'b0;
        end else begin
            r_op_start  <= 1'b0;
            r_cmd_error <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.cmd_valid) begin
                        if (w_known) begin
                            r_op_sel <= w_dec_sel;
                            r_state  <= c_WAIT_PREREQ;
                        end else begin
                            r_cmd_error <= 1'b1;
                        end
                    end
                end
                c_WAIT_PREREQ: begin
                    if (w_prereq_met) begin
                        if (w_needs_cdf) begin
                            r_state <= c_WAIT_CDF;
                        end else begin
                            r_state    <= c_RUN;
                            r_op_start <= 1'b1;
                        end
                    end
                end
                c_WAIT_CDF: begin
                    if (bus.CDF_generated) begin
                        r_state    <= c_RUN;
                        r_op_start <= 1'b1;
                    end
                end
                c_RUN: begin
                    if (bus.op_done) begin
                        r_op_sel <= '0;
                        r_state  <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_op_sel <= '0;
                    r_state  <= c_IDLE;
                end
            endcase

            // Watchdog expiry overrides any transition taken this cycle.
            if (w_timeout) begin
                r_state     <= c_IDLE;
                r_op_sel    <= '0;
                r_op_start  <= 1'b0;
                r_cmd_error <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready      = (r_state == c_IDLE);
    assign bus.cdf_start      = (r_state == c_WAIT_CDF);
    assign bus.cmd_done       = (r_state == c_DONE);
    assign bus.op_start       = r_op_start;
    assign bus.op_sel         = r_op_sel;
    assign bus.cmd_error      = r_cmd_error;
    assign bus.frame_complete = r_frame_complete;
    assign bus.block_count    = r_block_count;

endmodule

`default_nettype wire

// File: tb/tb_decoder_command_scheduler.sv
// ============================================================================
// Module      : tb_decoder_command_scheduler
// Description : Self-checking bench for decoder_command_scheduler with a
//               start/error scoreboard. Timeout scenario runs under
//               SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoder_command_scheduler;

    localparam int c_BCW = 11;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   n_starts;
    int   n_done;

    // bit6 = error expected, bits5:0 = op_sel expected at op_start
    logic [6:0] sb_q[$];

    decoder_command_scheduler_if #(.BLOCK_COUNT_WIDTH(c_BCW)) bus ();

    decoder_command_scheduler #(
        .IMAGE_WIDTH     (320),
        .IMAGE_HEIGHT    (240),
        .TABLE_EDGE_SIZE (8),
        .TIMEOUT_CYCLES  (16)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, "_op_sel"}, 32'(bus.op_sel), 32'd0);
        chk({tag, "_block_count"}, 32'(bus.block_count), 32'd0);
        chk({tag, "_pulses"}, 32'({bus.op_start, bus.cmd_done, bus.cmd_error,
                                    bus.cdf_start, bus.frame_complete}), 32'd0);
    endtask

    task automatic issue(input logic [15:0] code);
        bus.command   = code;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Scoreboard monitor: pops an expectation for every start or error pulse.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.op_start) begin
                n_starts++;
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_start", 32'd1, 32'd0);
                end else begin
                    logic [6:0] e;
                    e = sb_q.pop_front();
                    chk("sb_start_kind", 32'(e[6]), 32'd0);
                    chk("sb_op_sel", 32'(bus.op_sel), 32'(e[5:0]));
                end
            end
            if (bus.cmd_error) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_error", 32'd1, 32'd0);
                end else begin
                    logic [6:0] e;
                    e = sb_q.pop_front();
                    chk("sb_error_kind", 32'(e[6]), 32'd1);
                end
            end
            if (bus.cmd_done) n_done++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic found;
        int   starts0;
        int   cnt;
        n_checks = 0; n_errors = 0; n_starts = 0; n_done = 0;
        rst = 1'b0;
        bus.cmd_valid = 1'b0; bus.command = 16'h0000;
        bus.new_frame = 1'b0; bus.block_done = 1'b0;
        bus.histogram_generated = 1'b0; bus.CDF_generated = 1'b0;
        bus.op_done = 1'b0;
        repeat (2) tick();
        chk_reset_outputs("reset");
        rst = 1'b1;
        tick();

        // Frame fill up to and past saturation.
        bus.new_frame = 1'b1; tick(); bus.new_frame = 1'b0;
        bus.block_done = 1'b1;
        repeat (1199) tick();
        chk("bc_1199", 32'(bus.block_count), 32'd1199);
        chk("fc_before_last", 32'(bus.frame_complete), 32'd0);
        tick();
        chk("bc_1200", 32'(bus.block_count), 32'd1200);
        chk("fc_set", 32'(bus.frame_complete), 32'd1);
        tick();
        bus.block_done = 1'b0;
        chk("bc_saturate", 32'(bus.block_count), 32'd1200);

        // A010 latency: accept N, op_start N+2, op_done N+5, cmd_done N+6.
        sb_q.push_back(7'b0_000001);
        issue(16'hA010);
        chk("a010_ready_low", 32'(bus.cmd_ready), 32'd0);
        chk("a010_no_start_n1", 32'(bus.op_start), 32'd0);
        chk("a010_op_sel", 32'(bus.op_sel), 32'h01);
        tick();
        chk("a010_start_n2", 32'(bus.op_start), 32'd1);
        tick();
        chk("a010_start_n3", 32'(bus.op_start), 32'd0);
        tick(); tick();
        bus.op_done = 1'b1;
        chk("a010_no_done_n5", 32'(bus.cmd_done), 32'd0);
        tick();
        bus.op_done = 1'b0;
        chk("a010_done_n6", 32'(bus.cmd_done), 32'd1);
        chk("a010_ready_n6", 32'(bus.cmd_ready), 32'd0);
        tick();
        chk("a010_ready_n7", 32'(bus.cmd_ready), 32'd1);
        chk("a010_done_n7", 32'(bus.cmd_done), 32'd0);
        chk("a010_sel_clear", 32'(bus.op_sel), 32'd0);

        // A050 waits on histogram, then CDF; op_done in first RUN cycle.
        sb_q.push_back(7'b0_010000);
        issue(16'hA050);
        repeat (4) tick();
        chk("a050_no_cdf", 32'(bus.cdf_start), 32'd0);
        bus.histogram_generated = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            tick();
            if (bus.cdf_start) found = 1'b1;
        end
        chk("a050_cdf_start", 32'(found), 32'd1);
        tick(); tick();
        chk("a050_cdf_level", 32'(bus.cdf_start), 32'd1);
        chk("a050_no_start_in_cdf", 32'(bus.op_start), 32'd0);
        bus.CDF_generated = 1'b1;
        tick();
        bus.CDF_generated = 1'b0;
        chk("a050_start", 32'(bus.op_start), 32'd1);
        chk("a050_cdf_drop", 32'(bus.cdf_start), 32'd0);
        bus.op_done = 1'b1;
        tick();
        bus.op_done = 1'b0;
        chk("a050_done", 32'(bus.cmd_done), 32'd1);
        tick();
        chk("a050_ready", 32'(bus.cmd_ready), 32'd1);
        bus.histogram_generated = 1'b0;

        // Unknown code.
        sb_q.push_back(7'b1_000000);
        starts0 = n_starts;
        issue(16'hA070);
        chk("a070_error", 32'(bus.cmd_error), 32'd1);
        chk("a070_stay_idle", 32'(bus.cmd_ready), 32'd1);
        tick();
        chk("a070_error_pulse", 32'(bus.cmd_error), 32'd0);
        chk("a070_no_start", 32'(n_starts), 32'(starts0));

        // new_frame beats block_done.
        bus.new_frame = 1'b1; tick(); bus.new_frame = 1'b0;
        bus.block_done = 1'b1;
        repeat (500) tick();
        chk("bc_500", 32'(bus.block_count), 32'd500);
        bus.new_frame = 1'b1;
        tick();
        bus.new_frame = 1'b0; bus.block_done = 1'b0;
        chk("nf_wins_bc", 32'(bus.block_count), 32'd0);
        chk("nf_wins_fc", 32'(bus.frame_complete), 32'd0);

        // A030 waits across a new_frame, runs, then reset during RUN.
        sb_q.push_back(7'b0_000100);
        issue(16'hA030);
        starts0 = n_starts;
        bus.block_done = 1'b1;
        repeat (600) tick();
        bus.block_done = 1'b0; bus.new_frame = 1'b1;
        tick();
        bus.new_frame = 1'b0;
        chk("wait_nf_bc", 32'(bus.block_count), 32'd0);
        chk("wait_no_start", 32'(n_starts), 32'(starts0));
        chk("wait_busy", 32'(bus.cmd_ready), 32'd0);
        bus.block_done = 1'b1;
        repeat (1200) tick();
        bus.block_done = 1'b0;
        found = bus.op_start;
        for (int i = 0; i < 5 && !found; i++) begin
            tick();
            if (bus.op_start) found = 1'b1;
        end
        chk("a030_start", 32'(found), 32'd1);
        bus.new_frame = 1'b1; tick(); bus.new_frame = 1'b0;
        chk("run_nf_sel", 32'(bus.op_sel), 32'h04);
        chk("run_nf_busy", 32'(bus.cmd_ready), 32'd0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk_reset_outputs("run_reset");
        repeat (3) tick();
        chk("run_reset_no_done", 32'(n_done), 32'd2);

`ifdef SCHED_TIMEOUT_EN
        bus.block_done = 1'b1;
        repeat (1200) tick();
        bus.block_done = 1'b0;
        sb_q.push_back(7'b0_000010);
        sb_q.push_back(7'b1_000000);
        issue(16'hA020);
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            tick();
            if (bus.op_start) found = 1'b1;
        end
        chk("to_start", 32'(found), 32'd1);
        found = 1'b0; cnt = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            cnt++;
            if (bus.cmd_error) found = 1'b1;
        end
        chk("to_error", 32'(found), 32'd1);
        chk("to_cycles", 32'(cnt), 32'd16);
        chk("to_sel_clear", 32'(bus.op_sel), 32'd0);
        tick();
        chk("to_ready", 32'(bus.cmd_ready), 32'd1);
        chk("to_no_done", 32'(n_done), 32'd2);
`endif

        repeat (2) tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        chk("done_total", 32'(n_done), 32'd2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
